// File: rtl/pipe_control_if.sv
// Decode/Execute control-unit signal bundle shared by the pipeline control block and its neighbours.
// Latency: none (wiring only).
// Backpressure: none; the pipeline has no stall input and every register advances each cycle.
interface pipe_control_if #(
  parameter int ALUCTRL_W   = 4,
  parameter int RESULTSRC_W = 2
);

  // Decode-stage instruction and Execute-stage hazard/flag inputs
  logic [31:0]            InstrD;
  logic                   FlushE;
  logic                   ZeroE;
  logic                   LtE;
  logic                   LtuE;

  // Decode-stage combinational outputs
  logic [1:0]             ImmSrcD;
  logic                   IllegalD;

  // Execute-stage outputs
  logic [ALUCTRL_W-1:0]   ALUControlE;
  logic                   ALUSrcE;
  logic [RESULTSRC_W-1:0] ResultSrcE;
  logic                   PCSrcE;
  logic                   RegWriteE;

  // Memory-stage outputs
  logic                   RegWriteM;
  logic                   MemWriteM;

  // Writeback-stage outputs
  logic [RESULTSRC_W-1:0] ResultSrcW;
  logic                   RegWriteW;
  logic                   IllegalW;

  // Datapath/hazard side: drives the instruction and flags, consumes control
  modport master (
    output InstrD, FlushE, ZeroE, LtE, LtuE,
    input  ImmSrcD, IllegalD,
    input  ALUControlE, ALUSrcE, ResultSrcE, PCSrcE, RegWriteE,
    input  RegWriteM, MemWriteM,
    input  ResultSrcW, RegWriteW, IllegalW
  );

  // Control unit side
  modport slave (
    input  InstrD, FlushE, ZeroE, LtE, LtuE,
    output ImmSrcD, IllegalD,
    output ALUControlE, ALUSrcE, ResultSrcE, PCSrcE, RegWriteE,
    output RegWriteM, MemWriteM,
    output ResultSrcW, RegWriteW, IllegalW
  );

endinterface

// File: rtl/pipe_control.sv
// Pipelined RV32 control unit: decodes InstrD and carries the control word through D->E->M->W.
// Latency: decode is combinational; control reaches E/M/W 1/2/3 cycles after D; PCSrcE is combinational from E.
// Backpressure: none; FlushE bubbles the E register only. Define PIPE_CONTROL_BRANCHX_EN for bne/blt/bge/bltu/bgeu.
module pipe_control #(
  parameter int ALUCTRL_W   = 4,
  parameter int RESULTSRC_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  pipe_control_if.slave  ctl
);

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_RTYPE  = 7'd51;
  localparam logic [6:0] OP_ITYPE  = 7'd19;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [RESULTSRC_W-1:0] RES_ALU = RESULTSRC_W'(2'b00);
  localparam logic [RESULTSRC_W-1:0] RES_MEM = RESULTSRC_W'(2'b01);
  localparam logic [RESULTSRC_W-1:0] RES_PC4 = RESULTSRC_W'(2'b10);

  // Full control word as captured by the D->E register
  typedef struct packed {
    logic                   reg_write;
    logic [RESULTSRC_W-1:0] result_src;
    logic                   mem_write;
    logic                   jump;
    logic                   branch;
    logic [ALUCTRL_W-1:0]   alu_ctrl;
    logic                   alu_src;
    logic [2:0]             funct3;
    logic                   illegal;
  } ctrl_e_t;

  // Fields still needed after Execute
  typedef struct packed {
    logic                   reg_write;
    logic [RESULTSRC_W-1:0] result_src;
    logic                   mem_write;
    logic                   illegal;
  } ctrl_m_t;

  typedef struct packed {
    logic                   reg_write;
    logic [RESULTSRC_W-1:0] result_src;
    logic                   illegal;
  } ctrl_w_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_rtype;

  assign opcode   = ctl.InstrD[6:0];
  assign funct3   = ctl.InstrD[14:12];
  assign funct7   = ctl.InstrD[31:25];
  assign is_rtype = ctl.InstrD[5];

  // Register indices are decoded by the datapath, not here
  logic unused_ok;
  assign unused_ok = ^{ctl.InstrD[24:15], ctl.InstrD[11:7], ctl.LtE, ctl.LtuE};

  logic [3:0] alu_funct;
  logic       funct_bad;
  logic       branch_f3_ok;
  ctrl_e_t    ctrl_d;
  logic [1:0] imm_src_d;

  ctrl_e_t    ctrl_e;
  ctrl_m_t    ctrl_m;
  ctrl_w_t    ctrl_w;
  logic       taken_e;

  // ALU operation for R-type and I-type ALU instructions, with funct7 legality
  always_comb begin
    alu_funct = ALU_ADD;
    funct_bad = 1'b0;
    case (funct3)
      3'b000: begin
        if (is_rtype && funct7[5]) alu_funct = ALU_SUB;
        else                       alu_funct = ALU_ADD;
      end
      3'b001: begin
        alu_funct = ALU_SLL;
        if (funct7 != 7'h00) funct_bad = 1'b1;
      end
      3'b010: alu_funct = ALU_SLT;
      3'b011: alu_funct = ALU_SLTU;
      3'b100: alu_funct = ALU_XOR;
      3'b101: begin
        if (funct7 == 7'h20)      alu_funct = ALU_SRA;
        else if (funct7 == 7'h00) alu_funct = ALU_SRL;
        else                      funct_bad = 1'b1;
      end
      3'b110: alu_funct = ALU_OR;
      default: alu_funct = ALU_AND;
    endcase
    // For R-type the whole funct7 field is opcode space; only base and alternate encodings exist
    if (is_rtype && (funct7 != 7'h00) && (funct7 != 7'h20)) funct_bad = 1'b1;
    if (funct_bad) alu_funct = ALU_ADD;
  end

  // Which branch funct3 codes this build implements
  always_comb begin
`ifdef PIPE_CONTROL_BRANCHX_EN
    branch_f3_ok = (funct3 != 3'b010) && (funct3 != 3'b011);
`else
    branch_f3_ok = (funct3 == 3'b000);
`endif
  end

  // Main opcode decode into the control word and immediate type
  always_comb begin
    ctrl_d        = '0;
    ctrl_d.funct3 = funct3;
    imm_src_d     = IMM_I;
    case (opcode)
      OP_LOAD: begin
        ctrl_d.result_src = RES_MEM;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        imm_src_d         = IMM_I;
      end
      OP_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src_d        = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALUCTRL_W'(alu_funct);
        ctrl_d.illegal   = funct_bad;
      end
      OP_ITYPE: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = ALUCTRL_W'(alu_funct);
        ctrl_d.illegal   = funct_bad;
        imm_src_d        = IMM_I;
      end
      OP_BRANCH: begin
        ctrl_d.alu_ctrl = ALUCTRL_W'(ALU_SUB);
        imm_src_d       = IMM_B;
        if (branch_f3_ok) ctrl_d.branch  = 1'b1;
        else              ctrl_d.illegal = 1'b1;
      end
      OP_JAL: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.result_src = RES_PC4;
        ctrl_d.reg_write  = 1'b1;
        imm_src_d         = IMM_J;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  // Decode outputs read zero while reset is held
  assign ctl.ImmSrcD  = rst ? 2'b00 : imm_src_d;
  assign ctl.IllegalD = rst ? 1'b0  : ctrl_d.illegal;

  // D->E register: reset and flush both load a bubble
  always_ff @(posedge clk) begin
    if (rst || ctl.FlushE) ctrl_e <= '0;
    else                   ctrl_e <= ctrl_d;
  end

  // E->M register: flush does not stall or bubble the later stages
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_m <= '0;
    end else begin
      ctrl_m.reg_write  <= ctrl_e.reg_write;
      ctrl_m.result_src <= ctrl_e.result_src;
      ctrl_m.mem_write  <= ctrl_e.mem_write;
      ctrl_m.illegal    <= ctrl_e.illegal;
    end
  end

  // M->W register
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_w <= '0;
    end else begin
      ctrl_w.reg_write  <= ctrl_m.reg_write;
      ctrl_w.result_src <= ctrl_m.result_src;
      ctrl_w.illegal    <= ctrl_m.illegal;
    end
  end

  // Branch condition evaluated in Execute from the ALU flags
  always_comb begin
`ifdef PIPE_CONTROL_BRANCHX_EN
    case (ctrl_e.funct3)
      3'b000:  taken_e = ctl.ZeroE;
      3'b001:  taken_e = !ctl.ZeroE;
      3'b100:  taken_e = ctl.LtE;
      3'b101:  taken_e = !ctl.LtE;
      3'b110:  taken_e = ctl.LtuE;
      3'b111:  taken_e = !ctl.LtuE;
      default: taken_e = 1'b0;
    endcase
`else
    taken_e = ctl.ZeroE;
`endif
  end

  assign ctl.PCSrcE      = (ctrl_e.branch & taken_e) | ctrl_e.jump;
  assign ctl.ALUControlE = ctrl_e.alu_ctrl;
  assign ctl.ALUSrcE     = ctrl_e.alu_src;
  assign ctl.ResultSrcE  = ctrl_e.result_src;
  assign ctl.RegWriteE   = ctrl_e.reg_write;

  assign ctl.RegWriteM   = ctrl_m.reg_write;
  assign ctl.MemWriteM   = ctrl_m.mem_write;

  assign ctl.ResultSrcW  = ctrl_w.result_src;
  assign ctl.RegWriteW   = ctrl_w.reg_write;
  assign ctl.IllegalW    = ctrl_w.illegal;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: reset state, decode, pipeline latency, flush, branch and reset-in-flight.
// Latency: checks E/M/W outputs 1/2/3 cycles after an instruction is presented at D.
// Backpressure: none; inputs change 1 ns after the rising edge, outputs sampled before the next edge.
module tb_pipe_control;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] ADDI     = 32'h00A00093;
  localparam logic [31:0] SUB      = 32'h40208133;
  localparam logic [31:0] SRLI     = 32'h00A0D093;
  localparam logic [31:0] SRA      = 32'h4020D133;
  localparam logic [31:0] AND_R    = 32'h0020F133;
  localparam logic [31:0] BAD_F7   = 32'h02000133;
  localparam logic [31:0] BAD_OP   = 32'h0000007F;
  localparam logic [31:0] LW       = 32'h0000A183;
  localparam logic [31:0] SW       = 32'h0020A223;
  localparam logic [31:0] BEQ      = 32'h00208463;
  localparam logic [31:0] BNE      = 32'h00209463;
  localparam logic [31:0] JAL      = 32'h010000EF;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pipe_control_if #(.ALUCTRL_W(4), .RESULTSRC_W(2)) ctl ();

  pipe_control #(.ALUCTRL_W(4), .RESULTSRC_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_RegWriteE"},   32'(ctl.RegWriteE),   32'd0);
    chk({pfx, "_ALUControlE"}, 32'(ctl.ALUControlE), 32'd0);
    chk({pfx, "_ALUSrcE"},     32'(ctl.ALUSrcE),     32'd0);
    chk({pfx, "_ResultSrcE"},  32'(ctl.ResultSrcE),  32'd0);
    chk({pfx, "_PCSrcE"},      32'(ctl.PCSrcE),      32'd0);
    chk({pfx, "_RegWriteM"},   32'(ctl.RegWriteM),   32'd0);
    chk({pfx, "_MemWriteM"},   32'(ctl.MemWriteM),   32'd0);
    chk({pfx, "_RegWriteW"},   32'(ctl.RegWriteW),   32'd0);
    chk({pfx, "_ResultSrcW"},  32'(ctl.ResultSrcW),  32'd0);
    chk({pfx, "_IllegalW"},    32'(ctl.IllegalW),    32'd0);
    chk({pfx, "_IllegalD"},    32'(ctl.IllegalD),    32'd0);
    chk({pfx, "_ImmSrcD"},     32'(ctl.ImmSrcD),     32'd0);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    ctl.InstrD = BAD_OP;
    ctl.FlushE = 1'b0;
    ctl.ZeroE  = 1'b0;
    ctl.LtE    = 1'b0;
    ctl.LtuE   = 1'b0;
    tick();
    tick();
    chk_all_zero("rst");
    rst        = 1'b0;

    // addi through all stages
    ctl.InstrD = ADDI;
    #1;
    chk("addi_IllegalD", 32'(ctl.IllegalD), 32'd0);
    chk("addi_ImmSrcD",  32'(ctl.ImmSrcD),  32'd0);
    tick();
    chk("addi_ALUControlE", 32'(ctl.ALUControlE), 32'd0);
    chk("addi_ALUSrcE",     32'(ctl.ALUSrcE),     32'd1);
    chk("addi_RegWriteE",   32'(ctl.RegWriteE),   32'd1);
    ctl.InstrD = NOP;
    tick();
    chk("addi_RegWriteM", 32'(ctl.RegWriteM), 32'd1);
    tick();
    chk("addi_RegWriteW",  32'(ctl.RegWriteW),  32'd1);
    chk("addi_ResultSrcW", 32'(ctl.ResultSrcW), 32'd0);
    chk("addi_IllegalW",   32'(ctl.IllegalW),   32'd0);

    // ALU encodings
    ctl.InstrD = SUB;
    tick();
    chk("sub_ALUControlE", 32'(ctl.ALUControlE), 32'd1);
    chk("sub_ALUSrcE",     32'(ctl.ALUSrcE),     32'd0);
    ctl.InstrD = SRLI;
    tick();
    chk("srli_ALUControlE", 32'(ctl.ALUControlE), 32'd8);
    chk("srli_ALUSrcE",     32'(ctl.ALUSrcE),     32'd1);
    ctl.InstrD = SRA;
    tick();
    chk("sra_ALUControlE", 32'(ctl.ALUControlE), 32'd9);
    ctl.InstrD = AND_R;
    tick();
    chk("and_ALUControlE", 32'(ctl.ALUControlE), 32'd2);

    // illegal funct7 then illegal opcode
    ctl.InstrD = BAD_F7;
    #1;
    chk("badf7_IllegalD", 32'(ctl.IllegalD), 32'd1);
    tick();
    chk("badf7_ALUControlE", 32'(ctl.ALUControlE), 32'd0);
    ctl.InstrD = BAD_OP;
    #1;
    chk("badop_IllegalD", 32'(ctl.IllegalD), 32'd1);
    tick();
    chk("badop_RegWriteE", 32'(ctl.RegWriteE), 32'd0);
    ctl.InstrD = NOP;
    tick();
    chk("badf7_IllegalW", 32'(ctl.IllegalW), 32'd1);
    tick();
    chk("badop_IllegalW",  32'(ctl.IllegalW),  32'd1);
    chk("badop_RegWriteW", 32'(ctl.RegWriteW), 32'd0);

    // lw and sw
    ctl.InstrD = LW;
    tick();
    chk("lw_ResultSrcE", 32'(ctl.ResultSrcE), 32'd1);
    chk("lw_ALUSrcE",    32'(ctl.ALUSrcE),    32'd1);
    ctl.InstrD = SW;
    #1;
    chk("sw_ImmSrcD", 32'(ctl.ImmSrcD), 32'd1);
    tick();
    chk("sw_RegWriteE", 32'(ctl.RegWriteE), 32'd0);
    ctl.InstrD = NOP;
    tick();
    chk("sw_MemWriteM", 32'(ctl.MemWriteM), 32'd1);
    chk("sw_RegWriteM", 32'(ctl.RegWriteM), 32'd0);
    chk("lw_ResultSrcW", 32'(ctl.ResultSrcW), 32'd1);
    chk("lw_RegWriteW",  32'(ctl.RegWriteW),  32'd1);

    // beq taken / not taken
    ctl.InstrD = BEQ;
    #1;
    chk("beq_ImmSrcD",  32'(ctl.ImmSrcD),  32'd2);
    chk("beq_IllegalD", 32'(ctl.IllegalD), 32'd0);
    tick();
    ctl.InstrD = NOP;
    ctl.ZeroE  = 1'b1;
    #1;
    chk("beq_z1_PCSrcE", 32'(ctl.PCSrcE), 32'd1);
    ctl.ZeroE  = 1'b0;
    #1;
    chk("beq_z0_PCSrcE",  32'(ctl.PCSrcE),    32'd0);
    chk("beq_RegWriteE",  32'(ctl.RegWriteE), 32'd0);
    chk("beq_ALUControlE", 32'(ctl.ALUControlE), 32'd1);
    tick();
    chk("beq_RegWriteM", 32'(ctl.RegWriteM), 32'd0);
    chk("beq_MemWriteM", 32'(ctl.MemWriteM), 32'd0);
    tick();
    chk("beq_RegWriteW", 32'(ctl.RegWriteW), 32'd0);

    // flushed lw: bubble in E, later stages advance
    ctl.InstrD = LW;
    ctl.FlushE = 1'b1;
    tick();
    ctl.FlushE = 1'b0;
    ctl.InstrD = NOP;
    chk("flush_ResultSrcE", 32'(ctl.ResultSrcE), 32'd0);
    chk("flush_RegWriteE",  32'(ctl.RegWriteE),  32'd0);
    chk("flush_ALUSrcE",    32'(ctl.ALUSrcE),    32'd0);
    chk("flush_M_advances", 32'(ctl.RegWriteM),  32'd1);
    tick();
    chk("flush_RegWriteM", 32'(ctl.RegWriteM), 32'd0);
    tick();
    chk("flush_RegWriteW",  32'(ctl.RegWriteW),  32'd0);
    chk("flush_ResultSrcW", 32'(ctl.ResultSrcW), 32'd0);

    // bne with ZeroE=0
    ctl.InstrD = BNE;
    ctl.ZeroE  = 1'b0;
    #1;
`ifdef PIPE_CONTROL_BRANCHX_EN
    chk("bne_IllegalD", 32'(ctl.IllegalD), 32'd0);
`else
    chk("bne_IllegalD", 32'(ctl.IllegalD), 32'd1);
`endif
    tick();
    ctl.InstrD = NOP;
    #1;
`ifdef PIPE_CONTROL_BRANCHX_EN
    chk("bne_PCSrcE", 32'(ctl.PCSrcE), 32'd1);
`else
    chk("bne_PCSrcE", 32'(ctl.PCSrcE), 32'd0);
`endif
    tick();
    tick();
`ifdef PIPE_CONTROL_BRANCHX_EN
    chk("bne_IllegalW", 32'(ctl.IllegalW), 32'd0);
`else
    chk("bne_IllegalW", 32'(ctl.IllegalW), 32'd1);
`endif

    // jal, then reset (with a coincident flush) while it sits in M
    ctl.InstrD = JAL;
    #1;
    chk("jal_ImmSrcD", 32'(ctl.ImmSrcD), 32'd3);
    tick();
    ctl.InstrD = NOP;
    chk("jal_PCSrcE",     32'(ctl.PCSrcE),     32'd1);
    chk("jal_RegWriteE",  32'(ctl.RegWriteE),  32'd1);
    chk("jal_ResultSrcE", 32'(ctl.ResultSrcE), 32'd2);
    tick();
    chk("jal_RegWriteM", 32'(ctl.RegWriteM), 32'd1);
    rst        = 1'b1;
    ctl.FlushE = 1'b1;
    tick();
    chk_all_zero("jalrst");
    rst        = 1'b0;
    ctl.FlushE = 1'b0;
    tick();
    chk("postrst_RegWriteM", 32'(ctl.RegWriteM), 32'd0);
    chk("postrst_RegWriteW", 32'(ctl.RegWriteW), 32'd0);
    chk("postrst_RegWriteE", 32'(ctl.RegWriteE), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
